// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer feeding a four-state debounce FSM.
// Produces a registered debounced level, its complement and one-cycle edge pulses.
module button_conditioner #(
    parameter int unsigned STABLE_COUNT = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic BTN,
    output logic LEVEL,
    output logic NotLEVEL,
    output logic RISE,
    output logic FALL
);

    typedef enum logic [1:0] {
        LowStable,
        RiseCheck,
        HighStable,
        FallCheck
    } state_t;

    localparam logic [7:0] LastCnt = 8'(STABLE_COUNT - 1);

    logic       r_sync1;
    logic       r_sync2;
    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_level;
    logic       r_rise;
    logic       r_fall;

    state_t     w_state_next;
    logic [7:0] w_cnt_next;
    logic       w_level_next;
    logic       w_rise_next;
    logic       w_fall_next;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= LowStable;
            r_cnt   <= 8'd0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= BTN;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_level_next = r_level;
        w_rise_next  = 1'b0;
        w_fall_next  = 1'b0;
        unique case (r_state)
            LowStable: begin
                if (r_sync2) begin
                    w_state_next = RiseCheck;
                    w_cnt_next   = 8'd1;
                end else begin
                    w_cnt_next   = 8'd0;
                end
            end
            RiseCheck: begin
                if (!r_sync2) begin
                    w_state_next = LowStable;
                    w_cnt_next   = 8'd0;
                end else if (r_cnt >= LastCnt) begin
                    w_state_next = HighStable;
                    w_cnt_next   = 8'd0;
                    w_level_next = 1'b1;
                    w_rise_next  = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + 8'd1;
                end
            end
            HighStable: begin
                if (!r_sync2) begin
                    w_state_next = FallCheck;
                    w_cnt_next   = 8'd1;
                end else begin
                    w_cnt_next   = 8'd0;
                end
            end
            FallCheck: begin
                if (r_sync2) begin
                    w_state_next = HighStable;
                    w_cnt_next   = 8'd0;
                end else if (r_cnt >= LastCnt) begin
                    w_state_next = LowStable;
                    w_cnt_next   = 8'd0;
                    w_level_next = 1'b0;
                    w_fall_next  = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = LowStable;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    assign LEVEL    = r_level;
    assign NotLEVEL = ~r_level;
    assign RISE     = r_rise;
    assign FALL     = r_fall;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter STABLE_COUNT, default 4, giving the number of consecutive cycles a synchronized input must hold a new value before it is accepted; legal range 2..255.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET_N, input, 1 bit: synchronous, active-low reset, sampled on the CLK rising edge.
REQ-004 The block SHALL have port BTN, input, 1 bit: raw, asynchronous, bouncing push-button level.
REQ-005 The block SHALL have port LEVEL, output, 1 bit: debounced button level; it drives D or CLK of downstream d_flipflop stages.
REQ-006 The block SHALL have port NotLEVEL, output, 1 bit: the complement of LEVEL at all times.
REQ-007 The block SHALL have port RISE, output, 1 bit: single-cycle pulse when LEVEL goes 0->1.
REQ-008 The block SHALL have port FALL, output, 1 bit: single-cycle pulse when LEVEL goes 1->0.

Function
REQ-009 BTN SHALL pass through a two-flop synchronizer (SYNC1 <= BTN, SYNC2 <= SYNC1); only SYNC2 feeds the FSM.
REQ-010 The FSM SHALL have four states: LOW_STABLE, RISE_CHECK, HIGH_STABLE, FALL_CHECK, plus an 8-bit counter CNT.
REQ-011 In LOW_STABLE: if SYNC2=1, go to RISE_CHECK with CNT<=1; otherwise hold with CNT<=0.
REQ-012 In RISE_CHECK with SYNC2=0 (bounce), return to LOW_STABLE with CNT<=0 and LEVEL unchanged.
REQ-013 In RISE_CHECK with SYNC2=1 and CNT=STABLE_COUNT-1, go to HIGH_STABLE, set LEVEL<=1 and RISE<=1, and set CNT<=0.
REQ-014 In RISE_CHECK with SYNC2=1 and CNT<STABLE_COUNT-1, stay and increment CNT.
REQ-015 HIGH_STABLE and FALL_CHECK SHALL mirror REQ-011..REQ-014 with SYNC2 polarity inverted; acceptance sets LEVEL<=0 and FALL<=1.
REQ-016 RISE and FALL SHALL be registered, high for exactly one cycle (the cycle after the accepting edge), and never high together.
REQ-017 Latency: BTN is first sampled high at edge n and held high. LEVEL and RISE SHALL assert after edge n+STABLE_COUNT+1 (edge n+5 at default). The same latency SHALL apply to falling transitions.
REQ-018 Any BTN pulse that leaves SYNC2 high for fewer than STABLE_COUNT consecutive FSM evaluations SHALL produce no change on LEVEL, RISE or FALL.
REQ-019 CNT SHALL never exceed STABLE_COUNT-1 and SHALL never wrap.
REQ-020 LEVEL SHALL change only on an accepting edge and SHALL be glitch-free, since it is a direct register output.

Reset
REQ-021 When RESET_N=0 at a CLK rising edge, SYNC1, SYNC2, LEVEL, RISE, FALL and CNT SHALL all be set to 0, and state SHALL go to LOW_STABLE; NotLEVEL is therefore 1.
REQ-022 Reset SHALL override all FSM activity, including mid-check and on an accepting edge; a pending RISE or FALL SHALL be discarded.
REQ-023 After RESET_N returns to 1 with BTN already high, the block SHALL treat it as a fresh rising input, so LEVEL rises STABLE_COUNT+1 edges after the first non-reset edge.
REQ-024 The block SHALL contain no initial-block state; reset is the only initialization.

Verification (STABLE_COUNT=4)
REQ-025 Scenario: RESET_N=0 for 2 cycles with BTN=1 -> LEVEL=0, NotLEVEL=1, RISE=0, FALL=0 throughout.
REQ-026 Scenario: clean press, BTN 0->1 held 10 cycles -> LEVEL=1 after 5th edge, RISE high exactly 1 cycle, FALL=0.
REQ-027 Scenario: bounce, BTN pattern 1,0,1,1,0 then 1 held -> no RISE during bounce; a single RISE 5 edges after the final stable 1 is sampled.
REQ-028 Scenario: a 3-cycle BTN high glitch from LOW_STABLE -> LEVEL stays 0 and no RISE or FALL.
REQ-029 Scenario: release after a stable press, BTN 1->0 held -> LEVEL=0 after 5th edge, FALL high exactly 1 cycle.
REQ-030 Scenario: RESET_N=0 asserted in RISE_CHECK with CNT=3 -> next cycle LEVEL=0, RISE=0, CNT=0; BTN still high -> RISE 5 edges after release.
